// File: rtl/eth_debug_pkg.sv
// Shared definitions for the session statistics block: FSM encoding,
// summary record length and default record header.
package eth_debug;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam int         REC_LEN  = 8;
    localparam logic [2:0] LAST_IDX = 3'(REC_LEN - 1);
    localparam logic [7:0] DEF_HDR  = 8'hA5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; exposes the value it will
// hold after the coming edge so a snapshot can include this cycle's event.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count_next
);

    logic [W-1:0] count;

    // Next value: clear wins, otherwise increment unless already all-ones.
    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (en && (count != {W{1'b1}})) begin
            count_next = count + W'(1);
        end else begin
            count_next = count;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/session_stats.sv
// Per-session frame/error/cycle statistics, emitted as an 8-byte summary
// record over a valid/ready byte stream when the session stops.
module session_stats
    import eth_debug::*;
#(
    parameter logic [7:0] HDR_BYTE = DEF_HDR,
    parameter int         CYC_W    = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       working,
    input  logic       stop,
    input  logic       frame_ok,
    input  logic       frame_err,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    state_t             state;
    state_t             next_state;
    logic               clr;
    logic               run_active;
    logic               handshake;
    logic [15:0]        frame_nxt;
    logic [15:0]        err_nxt;
    logic [CYC_W-1:0]   cyc_nxt;
    logic [15:0]        rec_frame;
    logic [15:0]        rec_err;
    logic [CYC_W-1:0]   rec_cyc;
    logic [2:0]         byte_idx;

    function automatic logic [7:0] rec_byte(input logic [2:0] idx,
                                            input logic [15:0] f,
                                            input logic [15:0] e,
                                            input logic [CYC_W-1:0] c);
        case (idx)
            3'd0:    rec_byte = HDR_BYTE;
            3'd1:    rec_byte = f[15:8];
            3'd2:    rec_byte = f[7:0];
            3'd3:    rec_byte = e[15:8];
            3'd4:    rec_byte = e[7:0];
            3'd5:    rec_byte = c[23:16];
            3'd6:    rec_byte = c[15:8];
            3'd7:    rec_byte = c[7:0];
            default: rec_byte = 8'h00;
        endcase
    endfunction

    assign clr        = (state == ST_IDLE) && start;
    assign run_active = (state == ST_RUN) && working;
    assign handshake  = tx_valid && tx_ready;
    assign busy       = (state != ST_IDLE);

    sat_counter #(.W(16)) u_frame_cnt (
        .clk(clk), .reset_n(reset_n), .clr(clr),
        .en(run_active && frame_ok), .count_next(frame_nxt)
    );

    sat_counter #(.W(16)) u_err_cnt (
        .clk(clk), .reset_n(reset_n), .clr(clr),
        .en(run_active && frame_err), .count_next(err_nxt)
    );

    sat_counter #(.W(CYC_W)) u_cyc_cnt (
        .clk(clk), .reset_n(reset_n), .clr(clr),
        .en(run_active), .count_next(cyc_nxt)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start has priority over a coincident stop in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_RUN;
                else       next_state = ST_IDLE;
            end
            ST_RUN: begin
                if (stop) next_state = ST_SEND;
                else      next_state = ST_RUN;
            end
            ST_SEND: begin
                if (handshake && (byte_idx == LAST_IDX)) next_state = ST_IDLE;
                else                                     next_state = ST_SEND;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Snapshot on stop, then step through the record one handshake at a time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rec_frame <= 16'h0000;
            rec_err   <= 16'h0000;
            rec_cyc   <= '0;
            byte_idx  <= 3'd0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            case (state)
                ST_RUN: begin
                    if (stop) begin
                        rec_frame <= frame_nxt;
                        rec_err   <= err_nxt;
                        rec_cyc   <= cyc_nxt;
                        byte_idx  <= 3'd0;
                        tx_valid  <= 1'b1;
                        tx_data   <= HDR_BYTE;
                    end
                end
                ST_SEND: begin
                    if (handshake) begin
                        if (byte_idx == LAST_IDX) begin
                            byte_idx <= 3'd0;
                            tx_valid <= 1'b0;
                            tx_data  <= 8'h00;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            tx_data  <= rec_byte(byte_idx + 3'd1, rec_frame, rec_err, rec_cyc);
                        end
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    tx_data  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: doc/session_stats.md
SESSION_STATS -- requirements
Module: session_stats

Interface
REQ-001 Parameter HDR_BYTE, default 8'hA5, is the first byte of every summary record.
REQ-002 Parameter CYC_W, default 24, is the width of the working-cycle counter and is fixed at 24 for the record format.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  single-cycle pulse: session begins; driven by the session state machine.
REQ-006 working  input  1  level: session active.
REQ-007 stop  input  1  single-cycle pulse: session ends.
REQ-008 frame_ok  input  1  single-cycle strobe: one good frame received.
REQ-009 frame_err  input  1  single-cycle strobe: one bad frame received.
REQ-010 tx_data  output  8  summary record byte.
REQ-011 tx_valid  output  1  tx_data holds a valid byte.
REQ-012 tx_ready  input  1  consumer accepts the byte when tx_valid and tx_ready are both high.
REQ-013 busy  output  1  high in RUN and SEND states.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and SEND.
REQ-015 In IDLE, start=1 SHALL clear all counters and enter RUN on the next edge.
REQ-016 In RUN, a frame_ok strobe with working=1 SHALL increment frame_cnt (16 bit).
REQ-017 In RUN, a frame_err strobe with working=1 SHALL increment err_cnt (16 bit).
REQ-018 frame_ok and frame_err asserted in the same cycle SHALL both be counted.
REQ-019 In RUN, cyc_cnt (24 bit) SHALL increment on every cycle with working=1.
REQ-020 All three counters SHALL saturate at all-ones and never wrap.
REQ-021 Strobes with working=0, and strobes in IDLE or SEND, SHALL be ignored.
REQ-022 In RUN, stop=1 SHALL snapshot the counters into the record register and enter SEND on the next edge.
REQ-023 A strobe coincident with stop SHALL be counted only if working=1 in that cycle.
REQ-024 The 8-byte record SHALL be, in order: HDR_BYTE, frame_cnt[15:8], frame_cnt[7:0], err_cnt[15:8], err_cnt[7:0], cyc_cnt[23:16], cyc_cnt[15:8], cyc_cnt[7:0].
REQ-025 tx_valid SHALL rise in the first cycle of SEND, one cycle after the stop pulse, presenting HDR_BYTE.
REQ-026 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL hold stable.
REQ-027 Each handshake SHALL advance to the next byte in the following cycle, so a continuously asserted tx_ready gives a throughput of one byte per cycle.
REQ-028 A handshake on byte 7 SHALL deassert tx_valid and return the FSM to IDLE on the same edge.
REQ-029 tx_valid SHALL be 0 in IDLE and RUN.
REQ-030 start SHALL be ignored in RUN and SEND.
REQ-031 stop SHALL be ignored in IDLE and SEND.
REQ-032 The record SHALL be taken from the snapshot, so counter activity in SEND cannot alter it.
REQ-033 start and stop asserted in the same IDLE cycle SHALL act as start only.

Reset
REQ-034 reset_n=0 SHALL immediately force: state IDLE, all counters 0, snapshot 0, byte index 0, tx_valid=0, tx_data=8'h00, busy=0.
REQ-035 Reset asserted mid-RUN or mid-SEND SHALL abort the session with no partial record emitted afterwards.
REQ-036 The first session after reset SHALL need a fresh start pulse.

Structure
REQ-037 The FSM state encoding, the record length constant (8) and the default header value SHALL live in a shared eth_debug package.
REQ-038 A single sub-module, sat_counter (parameterised width, clear, enable, saturating), SHALL be instantiated three times.
REQ-039 The byte mux SHALL be driven by a 3-bit byte index register.
REQ-040 There SHALL be no combinational path from tx_ready to tx_valid or tx_data.

Verification
REQ-041 Scenario: start; working high for 100 cycles carrying 5 frame_ok and 2 frame_err; stop; tx_ready=1 -> bytes A5 00 05 00 02 00 00 64, then tx_valid=0 and busy=0.
REQ-042 Scenario: frame_ok and frame_err together in 3 cycles -> record frame_cnt=3 and err_cnt=3.
REQ-043 Scenario: 70000 frame_ok strobes -> frame_cnt bytes FF FF (saturated).
REQ-044 Scenario: tx_ready toggled 1,0,0,1 pseudo-randomly -> all 8 bytes delivered in order, data held stable during stalls, no byte duplicated or dropped.
REQ-045 Scenario: reset_n pulsed low while byte 3 is pending -> tx_valid=0 immediately; IDLE; a later session reports fresh counts.
REQ-046 Scenario: start, frame strobes and stop issued during SEND -> no effect on the current record; FSM returns to IDLE after byte 7.
